// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
//
// Computes the next control-store address (microPC) for a microprogrammed
// CPU. The control store is addressed by a registered microPC. Each
// microinstruction selects its successor with its COND field:
//   +1, a flag- or IR13-conditional jump, an unconditional jump, or a
//   DECODE dispatch {1'b1, Op, Op3, 2'b00}.
// Memory accesses stall the sequencer in MEMWAIT until MemAck_In arrives.
//
// Optional feature: define MICRO_SEQUENCER_WATCHDOG_EN to build a memory-wait
// watchdog. After WATCHDOG_LIMIT MEMWAIT cycles with no acknowledge, the
// watchdog forces microPC to all-ones, pulses Timeout_Out for one cycle and
// returns to RUN. An acknowledge on the same edge wins over the timeout.
//
// Ports
//   MICRO_SEQUENCER_CLOCK_50           in   system clock (rising edge)
//   MICRO_SEQUENCER_ResetInLow_In      in   synchronous active-low reset
//   MICRO_SEQUENCER_Condition_InBus    in   COND field of current microinstr.
//   MICRO_SEQUENCER_JumpAddress_InBus  in   JUMP ADDR field
//   MICRO_SEQUENCER_MemRequest_In      in   RD or WR asserted by microinstr.
//   MICRO_SEQUENCER_MemAck_In          in   main memory completion strobe
//   MICRO_SEQUENCER_Op_InBus           in   IR[31:30]
//   MICRO_SEQUENCER_Op3_InBus          in   IR[24:19]
//   MICRO_SEQUENCER_IR13_In            in   IR[13], immediate select
//   MICRO_SEQUENCER_Flags_InBus        in   PSR {n,z,v,c}
//   MICRO_SEQUENCER_CSAddress_OutBus   out  registered microPC
//   MICRO_SEQUENCER_Wait_Out           out  high while in MEMWAIT
//   MICRO_SEQUENCER_Timeout_Out        out  one-cycle watchdog expiry pulse
//   MICRO_SEQUENCER_State_Out          out  FSM state (0 = RUN, 1 = MEMWAIT)
//
// Handshake: a memory access is requested by MemRequest_In in RUN. If
// MemAck_In is high on the same edge, the access completes at once. Otherwise
// the sequencer holds in MEMWAIT until an edge sees MemAck_In high. MemAck_In
// carries no meaning while no request is outstanding.
// -----------------------------------------------------------------------------
module micro_sequencer #(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int WATCHDOG_LIMIT        = 255
) (
    input  logic                             MICRO_SEQUENCER_CLOCK_50,
    input  logic                             MICRO_SEQUENCER_ResetInLow_In,
    input  logic [DATAWIDTH_CONDITION-1:0]   MICRO_SEQUENCER_Condition_InBus,
    input  logic [DATAWIDTH_JUMPADDRESS-1:0] MICRO_SEQUENCER_JumpAddress_InBus,
    input  logic                             MICRO_SEQUENCER_MemRequest_In,
    input  logic                             MICRO_SEQUENCER_MemAck_In,
    input  logic [1:0]                       MICRO_SEQUENCER_Op_InBus,
    input  logic [5:0]                       MICRO_SEQUENCER_Op3_InBus,
    input  logic                             MICRO_SEQUENCER_IR13_In,
    input  logic [3:0]                       MICRO_SEQUENCER_Flags_InBus,
    output logic [DATAWIDTH_JUMPADDRESS-1:0] MICRO_SEQUENCER_CSAddress_OutBus,
    output logic                             MICRO_SEQUENCER_Wait_Out,
    output logic                             MICRO_SEQUENCER_Timeout_Out,
    output logic                             MICRO_SEQUENCER_State_Out
);

    localparam int AW = DATAWIDTH_JUMPADDRESS;
    localparam int CW = DATAWIDTH_CONDITION;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [AW-1:0]   upc, upc_next;
    logic [AW-1:0]   advance_addr;
    logic [10:0]     decode_addr;
    logic            take_jump;
    logic            flag_n, flag_z, flag_v, flag_c;

    assign {flag_n, flag_z, flag_v, flag_c} = MICRO_SEQUENCER_Flags_InBus;

`ifdef MICRO_SEQUENCER_WATCHDOG_EN
    // The counter holds the number of MEMWAIT cycles already spent. On the
    // LIMIT-th waiting edge it equals LIMIT-1, and that edge expires.
    localparam logic [7:0] WD_LAST = 8'(WATCHDOG_LIMIT - 1);

    logic [7:0] wd_cnt, wd_cnt_next;
    logic       timeout_q, timeout_next;
`endif

    // Address taken when the current microinstruction retires.
    always_comb begin
        decode_addr  = {1'b1, MICRO_SEQUENCER_Op_InBus, MICRO_SEQUENCER_Op3_InBus, 2'b00};
        take_jump    = 1'b0;
        advance_addr = upc + AW'(1);  // wraps modulo 2^AW
        case (MICRO_SEQUENCER_Condition_InBus)
            CW'(1):  take_jump = flag_n;
            CW'(2):  take_jump = flag_z;
            CW'(3):  take_jump = flag_v;
            CW'(4):  take_jump = flag_c;
            CW'(5):  take_jump = MICRO_SEQUENCER_IR13_In;
            CW'(6):  take_jump = 1'b1;
            default: take_jump = 1'b0;
        endcase
        if (MICRO_SEQUENCER_Condition_InBus == CW'(7)) begin
            advance_addr = AW'(decode_addr);
        end else if (take_jump) begin
            advance_addr = MICRO_SEQUENCER_JumpAddress_InBus;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        upc_next   = upc;
`ifdef MICRO_SEQUENCER_WATCHDOG_EN
        wd_cnt_next  = wd_cnt;
        timeout_next = 1'b0;
`endif
        case (state)
            RUN: begin
                if (MICRO_SEQUENCER_MemRequest_In && !MICRO_SEQUENCER_MemAck_In) begin
                    state_next = MEMWAIT;
`ifdef MICRO_SEQUENCER_WATCHDOG_EN
                    wd_cnt_next = 8'd0;
`endif
                end else begin
                    upc_next = advance_addr;
                end
            end
            MEMWAIT: begin
                if (MICRO_SEQUENCER_MemAck_In) begin
                    upc_next   = advance_addr;
                    state_next = RUN;
                end
`ifdef MICRO_SEQUENCER_WATCHDOG_EN
                else if (wd_cnt == WD_LAST) begin
                    upc_next     = '1;
                    timeout_next = 1'b1;
                    state_next   = RUN;
                end else begin
                    wd_cnt_next = wd_cnt + 8'd1;
                end
`endif
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge MICRO_SEQUENCER_CLOCK_50) begin
        if (!MICRO_SEQUENCER_ResetInLow_In) begin
            state <= RUN;
            upc   <= '0;
`ifdef MICRO_SEQUENCER_WATCHDOG_EN
            wd_cnt    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            upc   <= upc_next;
`ifdef MICRO_SEQUENCER_WATCHDOG_EN
            wd_cnt    <= wd_cnt_next;
            timeout_q <= timeout_next;
`endif
        end
    end

    assign MICRO_SEQUENCER_CSAddress_OutBus = upc;
    assign MICRO_SEQUENCER_Wait_Out         = (state == MEMWAIT);
    assign MICRO_SEQUENCER_State_Out        = state;

`ifdef MICRO_SEQUENCER_WATCHDOG_EN
    assign MICRO_SEQUENCER_Timeout_Out = timeout_q;
`else
    // No watchdog: the limit is meaningless and this compare is a constant 0.
    assign MICRO_SEQUENCER_Timeout_Out = (WATCHDOG_LIMIT < 0);
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// -----------------------------------------------------------------------------
// tb_micro_sequencer
//
// Directed self-checking bench for micro_sequencer. Inputs change about 1ns
// after each rising edge. Outputs are sampled at that same point, so every
// check reads the value registered by the edge just taken. The watchdog
// scenario follows MICRO_SEQUENCER_WATCHDOG_EN, and the DUT is built with
// WATCHDOG_LIMIT = 4.
// -----------------------------------------------------------------------------
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  cond;
    logic [10:0] jump;
    logic        req;
    logic        ack;
    logic [1:0]  op;
    logic [5:0]  op3;
    logic        ir13;
    logic [3:0]  flags;
    logic [10:0] cs_addr;
    logic        wait_o;
    logic        timeout;
    logic        state_o;

    int tests_run    = 0;
    int tests_failed = 0;

    micro_sequencer #(
        .DATAWIDTH_JUMPADDRESS(11),
        .DATAWIDTH_CONDITION  (3),
        .WATCHDOG_LIMIT       (4)
    ) dut (
        .MICRO_SEQUENCER_CLOCK_50         (clk),
        .MICRO_SEQUENCER_ResetInLow_In    (rst_n),
        .MICRO_SEQUENCER_Condition_InBus  (cond),
        .MICRO_SEQUENCER_JumpAddress_InBus(jump),
        .MICRO_SEQUENCER_MemRequest_In    (req),
        .MICRO_SEQUENCER_MemAck_In        (ack),
        .MICRO_SEQUENCER_Op_InBus         (op),
        .MICRO_SEQUENCER_Op3_InBus        (op3),
        .MICRO_SEQUENCER_IR13_In          (ir13),
        .MICRO_SEQUENCER_Flags_InBus      (flags),
        .MICRO_SEQUENCER_CSAddress_OutBus (cs_addr),
        .MICRO_SEQUENCER_Wait_Out         (wait_o),
        .MICRO_SEQUENCER_Timeout_Out      (timeout),
        .MICRO_SEQUENCER_State_Out        (state_o)
    );

    // Clock and global time bound.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL time_limit: bench still running at %0t, required finish", $time);
        $fatal(1, "time limit");
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cond  = 3'b000;
        jump  = 11'd0;
        req   = 1'b0;
        ack   = 1'b0;
        op    = 2'b00;
        op3   = 6'b000000;
        ir13  = 1'b0;
        flags = 4'b0000;
    endtask

    // Reset, then take one unconditional jump to land on addr.
    task automatic goto_addr(input logic [10:0] addr);
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cond  = 3'b110;
        jump  = addr;
        step();
        idle_inputs();
    endtask

    // Scenarios.
    task automatic test_reset();
        idle_inputs();
        req   = 1'b1;
        cond  = 3'b110;
        jump  = 11'd99;
        rst_n = 1'b0;
        step();
        step();
        tests_run++;
        if (cs_addr !== 11'd0) begin tests_failed++; $display("FAIL reset_addr: got %0d want 0", cs_addr); end
        tests_run++;
        if (wait_o !== 1'b0) begin tests_failed++; $display("FAIL reset_wait: got %b want 0", wait_o); end
        tests_run++;
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        tests_run++;
        if (state_o !== 1'b0) begin tests_failed++; $display("FAIL reset_state: got %b want 0", state_o); end
    endtask

    task automatic test_sequential();
        idle_inputs();
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            tests_run++;
            if (cs_addr !== 11'(i)) begin tests_failed++; $display("FAIL seq_inc%0d: got %0d want %0d", i, cs_addr, i); end
        end
    endtask

    task automatic test_decode();
        goto_addr(11'd1);
        cond = 3'b111;
        op   = 2'b10;
        op3  = 6'b010000;
        step();
        tests_run++;
        if (cs_addr !== 11'd1600) begin tests_failed++; $display("FAIL decode: got %0d want 1600", cs_addr); end
    endtask

    task automatic test_ir13();
        goto_addr(11'd1600);
        cond = 3'b101;
        jump = 11'd1602;
        ir13 = 1'b1;
        step();
        tests_run++;
        if (cs_addr !== 11'd1602) begin tests_failed++; $display("FAIL ir13_set: got %0d want 1602", cs_addr); end
        goto_addr(11'd1600);
        cond = 3'b101;
        jump = 11'd1602;
        ir13 = 1'b0;
        step();
        tests_run++;
        if (cs_addr !== 11'd1601) begin tests_failed++; $display("FAIL ir13_clr: got %0d want 1601", cs_addr); end
    endtask

    // COND 1..4 select n,z,v,c = flags[3..0].
    task automatic test_flags();
        logic [3:0] bit_mask;
        for (int k = 1; k <= 4; k++) begin
            bit_mask = 4'b1000 >> (k - 1);
            goto_addr(11'd100);
            cond  = 3'(k);
            jump  = 11'd500;
            flags = bit_mask;
            step();
            tests_run++;
            if (cs_addr !== 11'd500) begin tests_failed++; $display("FAIL flag_taken_c%0d: got %0d want 500", k, cs_addr); end
            goto_addr(11'd100);
            cond  = 3'(k);
            jump  = 11'd500;
            flags = ~bit_mask;
            step();
            tests_run++;
            if (cs_addr !== 11'd101) begin tests_failed++; $display("FAIL flag_not_taken_c%0d: got %0d want 101", k, cs_addr); end
        end
    endtask

    task automatic test_memwait();
        goto_addr(11'd0);
        req = 1'b1;
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (cs_addr !== 11'd0 || wait_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL memwait_hold%0d: got addr %0d wait %b want addr 0 wait 1", i, cs_addr, wait_o);
            end
            // These inputs must not affect the held address.
            cond  = 3'b110;
            jump  = 11'd77;
            flags = 4'b1111;
        end
        cond = 3'b000;
        ack  = 1'b1;
        step();
        tests_run++;
        if (cs_addr !== 11'd1 || wait_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL memwait_release: got addr %0d wait %b want addr 1 wait 0", cs_addr, wait_o);
        end
        // Request with an acknowledge on the same edge advances with no stall.
        req = 1'b1;
        ack = 1'b1;
        step();
        tests_run++;
        if (cs_addr !== 11'd2 || wait_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL req_ack_same: got addr %0d wait %b want addr 2 wait 0", cs_addr, wait_o);
        end
        // Acknowledge with no request is ignored.
        req = 1'b0;
        ack = 1'b1;
        step();
        tests_run++;
        if (cs_addr !== 11'd3 || wait_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_ack: got addr %0d wait %b want addr 3 wait 0", cs_addr, wait_o);
        end
        idle_inputs();
    endtask

    task automatic test_wrap_and_reset_override();
        goto_addr(11'd2047);
        step();
        tests_run++;
        if (cs_addr !== 11'd0) begin tests_failed++; $display("FAIL wrap: got %0d want 0", cs_addr); end
        goto_addr(11'd5);
        req = 1'b1;
        step();
        tests_run++;
        if (wait_o !== 1'b1) begin tests_failed++; $display("FAIL enter_wait: got %b want 1", wait_o); end
        rst_n = 1'b0;
        step();
        tests_run++;
        if (cs_addr !== 11'd0 || state_o !== 1'b0 || wait_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_wait: got addr %0d state %b wait %b want 0 0 0", cs_addr, state_o, wait_o);
        end
        rst_n = 1'b1;
        req   = 1'b0;
        step();
        tests_run++;
        if (cs_addr !== 11'd1) begin tests_failed++; $display("FAIL first_after_reset: got %0d want 1", cs_addr); end
    endtask

`ifdef MICRO_SEQUENCER_WATCHDOG_EN
    task automatic test_watchdog();
        goto_addr(11'd10);
        req = 1'b1;
        step();
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i < 4) begin
                tests_run++;
                if (cs_addr !== 11'd10 || wait_o !== 1'b1 || timeout !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL wd_wait%0d: got addr %0d wait %b to %b want 10 1 0", i, cs_addr, wait_o, timeout);
                end
            end else begin
                tests_run++;
                if (cs_addr !== 11'd2047 || wait_o !== 1'b0 || timeout !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL wd_expire: got addr %0d wait %b to %b want 2047 0 1", cs_addr, wait_o, timeout);
                end
            end
        end
        req = 1'b0;
        step();
        tests_run++;
        if (timeout !== 1'b0 || cs_addr !== 11'd0) begin
            tests_failed++;
            $display("FAIL wd_pulse_end: got addr %0d to %b want 0 0", cs_addr, timeout);
        end
        // An acknowledge on the expiry edge wins.
        goto_addr(11'd10);
        req = 1'b1;
        step();
        step();
        step();
        step();
        ack = 1'b1;
        step();
        tests_run++;
        if (cs_addr !== 11'd11 || timeout !== 1'b0 || wait_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_ack_priority: got addr %0d to %b wait %b want 11 0 0", cs_addr, timeout, wait_o);
        end
        idle_inputs();
    endtask
`else
    task automatic test_watchdog();
        goto_addr(11'd10);
        req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            tests_run++;
            if (cs_addr !== 11'd10 || wait_o !== 1'b1 || timeout !== 1'b0) begin
                tests_failed++;
                $display("FAIL nowd_wait%0d: got addr %0d wait %b to %b want 10 1 0", i, cs_addr, wait_o, timeout);
            end
        end
        ack = 1'b1;
        step();
        tests_run++;
        if (cs_addr !== 11'd11 || wait_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL nowd_release: got addr %0d wait %b want 11 0", cs_addr, wait_o);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_decode();
        test_ir13();
        test_flags();
        test_memwait();
        test_wrap_and_reset_override();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter DATAWIDTH_JUMPADDRESS, default 11, the control-store address width.
REQ-002 SHALL have parameter DATAWIDTH_CONDITION, default 3, the microinstruction COND field width.
REQ-003 SHALL have parameter WATCHDOG_LIMIT, default 255, the memory-wait cycles before timeout; used only with MICRO_SEQUENCER_WATCHDOG_EN.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 MICRO_SEQUENCER_CLOCK_50  in  1  system clock; all state updates on its rising edge.
REQ-006 MICRO_SEQUENCER_ResetInLow_In  in  1  synchronous active-low reset.
REQ-007 MICRO_SEQUENCER_Condition_InBus  in  3  COND field of the current microinstruction.
REQ-008 MICRO_SEQUENCER_JumpAddress_InBus  in  11  JUMP ADDR field of the current microinstruction.
REQ-009 MICRO_SEQUENCER_MemRequest_In  in  1  RD or WR asserted by the current microinstruction.
REQ-010 MICRO_SEQUENCER_MemAck_In  in  1  main memory completion strobe.
REQ-011 MICRO_SEQUENCER_Op_InBus  in  2  IR[31:30].
REQ-012 MICRO_SEQUENCER_Op3_InBus  in  6  IR[24:19].
REQ-013 MICRO_SEQUENCER_IR13_In  in  1  IR[13], immediate select.
REQ-014 MICRO_SEQUENCER_Flags_InBus  in  4  PSR {n,z,v,c}.
REQ-015 MICRO_SEQUENCER_CSAddress_OutBus  out  11  registered microPC; drives the control store address input.
REQ-016 MICRO_SEQUENCER_Wait_Out  out  1  high while in state MEMWAIT.
REQ-017 MICRO_SEQUENCER_Timeout_Out  out  1  one-cycle pulse on watchdog expiry; constant 0 when the watchdog is compiled out.

Function
REQ-018 SHALL hold a two-state FSM: RUN, MEMWAIT.
REQ-019 In RUN, with MemRequest_In=0, or MemRequest_In=1 and MemAck_In=1: SHALL load the next address per REQ-021 and stay in RUN.
REQ-020 In RUN, with MemRequest_In=1 and MemAck_In=0: SHALL hold the microPC, enter MEMWAIT, and clear the wait counter.
REQ-021 Next-address select by COND:
- 000: microPC+1.
- 001: JumpAddress if n, else +1.
- 010: JumpAddress if z, else +1.
- 011: JumpAddress if v, else +1.
- 100: JumpAddress if c, else +1.
- 101: JumpAddress if IR13, else +1.
- 110: JumpAddress unconditionally.
- 111: DECODE address {1'b1, Op, Op3, 2'b00}.
REQ-022 microPC+1 SHALL be computed modulo 2^11; 2047 wraps to 0.
REQ-023 Flags and IR inputs SHALL be sampled only on the advancing edge; values during MEMWAIT are ignored.
REQ-024 In MEMWAIT: MemAck_In=1 SHALL load the next address per REQ-021 from the current inputs and return to RUN; MemAck_In=0 SHALL hold the microPC.
REQ-025 MemAck_In while MemRequest_In=0 SHALL be ignored.
REQ-026 Latency: one edge per microinstruction without memory access; 1+k edges with a memory wait of k cycles.

Reset
REQ-027 While ResetInLow_In=0 at an edge, the block SHALL set microPC=0, state=RUN, Wait_Out=0, Timeout_Out=0 and the wait counter to 0, overriding all other inputs including a pending MEMWAIT.
REQ-028 The first edge after reset release SHALL evaluate the microinstruction at address 0.

Configuration
REQ-029 With MICRO_SEQUENCER_WATCHDOG_EN defined:
- An 8-bit counter SHALL count MEMWAIT cycles.
- When the count reaches WATCHDOG_LIMIT without MemAck_In, the block SHALL force microPC=2047, pulse Timeout_Out for one cycle, and return to RUN.
- MemAck_In on the same edge SHALL take priority over the timeout.
REQ-030 Without MICRO_SEQUENCER_WATCHDOG_EN: no counter is built, MEMWAIT lasts indefinitely, and Timeout_Out is tied to 0.

Verification
REQ-031 Release reset with COND=000 and no request for 3 edges -> CSAddress 0,1,2,3.
REQ-032 At address 1: COND=111, Op=10, Op3=010000 -> next CSAddress 11001000000 (1600).
REQ-033 At 1600: COND=101, Jump=1602, IR13=1 -> 1602; repeat with IR13=0 -> 1601.
REQ-034 At 0: MemRequest=1, MemAck low 3 cycles then high -> CSAddress holds 0 for 3 edges with Wait_Out=1, then becomes 1 and Wait_Out=0.
REQ-035 At 2047 with COND=000 -> 0; assert ResetInLow=0 during MEMWAIT -> CSAddress 0, state RUN on the next edge.
REQ-036 With the watchdog enabled and LIMIT=4, MemAck held low -> CSAddress 2047 and a single Timeout_Out pulse after 4 wait cycles.
